// File: rtl/gem_ext_fifo_rx_if.sv
// Bus bundles for gem_ext_fifo_rx: the GEM external-FIFO receive side
// (master = MAC, slave = bridge) and the AXI4-Stream output (master = bridge).
interface gem_ext_fifo_rx_if;
    logic [7:0]  gem_rx_data;
    logic        gem_rx_wr;
    logic        gem_rx_sop;
    logic        gem_rx_eop;
    logic        gem_rx_err;
    logic        gem_rx_flush;
    logic [44:0] gem_rx_status;
    logic        gem_rx_overflow;
    logic        gem_dma_rx_end_tog;
    logic        gem_dma_rx_status_tog;

    modport master (
        output gem_rx_data, gem_rx_wr, gem_rx_sop, gem_rx_eop, gem_rx_err,
               gem_rx_flush, gem_rx_status, gem_dma_rx_end_tog,
        input  gem_rx_overflow, gem_dma_rx_status_tog
    );

    modport slave (
        input  gem_rx_data, gem_rx_wr, gem_rx_sop, gem_rx_eop, gem_rx_err,
               gem_rx_flush, gem_rx_status, gem_dma_rx_end_tog,
        output gem_rx_overflow, gem_dma_rx_status_tog
    );
endinterface

interface gem_ext_fifo_rx_axis_if;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       m_axis_tkeep;

    modport master (
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep,
        output m_axis_tready
    );
endinterface

// File: rtl/gem_ext_fifo_rx.sv
// GEM external-FIFO receive to AXI4-Stream bridge with frame-aware overflow dropping.
// Optional status capture is enabled by defining GEM_EXT_FIFO_RX_STATUS_EN.
module gem_ext_fifo_rx #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    gem_ext_fifo_rx_if.slave        gem,
    gem_ext_fifo_rx_axis_if.master  m_axis,
    output logic [44:0]             rx_status,
    output logic                    rx_status_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LIM_DATA = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM_TERM = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_endTogQ;
    logic          r_statusTog;

    logic          w_pushReq;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf;
    logic          w_eopStored;
    logic          w_spaceData;
    logic          w_spaceTerm;
    logic [9:0]    w_pushEntry;
    logic [9:0]    w_head;

    // The last slot is kept free so a frame can always be closed with a terminator.
    assign w_spaceData = (r_count < LIM_DATA);
    assign w_spaceTerm = (r_count < LIM_TERM);
    assign w_push      = w_pushReq && w_spaceTerm;
    assign w_pop       = m_axis.m_axis_tvalid && m_axis.m_axis_tready;
    assign w_head      = r_mem[r_rdPtr];

    always_comb begin
        w_stateNext = r_state;
        w_pushReq   = 1'b0;
        w_pushEntry = '0;
        w_ovf       = 1'b0;
        w_eopStored = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (gem.gem_rx_wr && gem.gem_rx_sop) begin
                    if (gem.gem_rx_eop) begin
                        if (w_spaceTerm) begin
                            w_pushReq   = 1'b1;
                            w_pushEntry = {gem.gem_rx_err, 1'b1, gem.gem_rx_data};
                            w_eopStored = 1'b1;
                        end else begin
                            w_ovf = 1'b1;
                        end
                    end else if (w_spaceData) begin
                        w_pushReq   = 1'b1;
                        w_pushEntry = {1'b0, 1'b0, gem.gem_rx_data};
                        w_stateNext = PKT;
                    end else begin
                        w_ovf       = 1'b1;
                        w_stateNext = DROP;
                    end
                end else if (gem.gem_rx_wr) begin
                    w_ovf = 1'b1;
                end
            end
            PKT: begin
                if (gem.gem_rx_flush) begin
                    w_pushReq   = 1'b1;
                    w_pushEntry = {1'b1, 1'b1, 8'h00};
                    w_stateNext = DROP;
                end else if (gem.gem_rx_wr) begin
                    if (gem.gem_rx_sop) begin
                        // A new sop mid-frame means the previous eop was lost; close it as bad.
                        w_pushReq   = 1'b1;
                        w_pushEntry = {1'b1, 1'b1, gem.gem_rx_data};
                        w_ovf       = 1'b1;
                        w_stateNext = gem.gem_rx_eop ? IDLE : DROP;
                    end else if (gem.gem_rx_eop) begin
                        w_pushReq   = 1'b1;
                        w_pushEntry = {gem.gem_rx_err, 1'b1, gem.gem_rx_data};
                        w_eopStored = 1'b1;
                        w_stateNext = IDLE;
                    end else if (w_spaceData) begin
                        w_pushReq   = 1'b1;
                        w_pushEntry = {1'b0, 1'b0, gem.gem_rx_data};
                    end else begin
                        w_pushReq   = 1'b1;
                        w_pushEntry = {1'b1, 1'b1, gem.gem_rx_data};
                        w_ovf       = 1'b1;
                        w_stateNext = DROP;
                    end
                end
            end
            DROP: begin
                if (gem.gem_rx_wr && gem.gem_rx_eop) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_endTogQ   <= 1'b0;
            r_statusTog <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_overflow <= w_ovf;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_endTogQ   <= gem.gem_dma_rx_end_tog;
            r_statusTog <= r_statusTog ^ (gem.gem_dma_rx_end_tog ^ r_endTogQ);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushEntry;
        end
    end

    assign m_axis.m_axis_tvalid     = (r_count != '0);
    assign m_axis.m_axis_tdata      = w_head[7:0];
    assign m_axis.m_axis_tlast      = w_head[8];
    assign m_axis.m_axis_tuser      = w_head[9];
    assign m_axis.m_axis_tkeep      = 1'b1;
    assign gem.gem_rx_overflow       = r_overflow;
    assign gem.gem_dma_rx_status_tog = r_statusTog;

`ifdef GEM_EXT_FIFO_RX_STATUS_EN
    logic [44:0] r_rxStatus;
    logic        r_rxStatusValid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxStatus      <= '0;
            r_rxStatusValid <= 1'b0;
        end else begin
            r_rxStatusValid <= w_eopStored && w_push;
            if (w_eopStored && w_push) begin
                r_rxStatus <= gem.gem_rx_status;
            end
        end
    end

    assign rx_status       = r_rxStatus;
    assign rx_status_valid = r_rxStatusValid;
`else
    logic w_unusedStatus;
    assign w_unusedStatus  = ^{gem.gem_rx_status, w_eopStored};
    assign rx_status       = '0;
    assign rx_status_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gem_ext_fifo_rx.sv
// Randomized scoreboard bench for gem_ext_fifo_rx: a frame-level reference model
// queues expected beats, and a negedge monitor compares every AXIS beat and side output.
module tb_gem_ext_fifo_rx;
    localparam int DEPTH = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    gem_ext_fifo_rx_if      gemIf();
    gem_ext_fifo_rx_axis_if axisIf();
    logic [44:0] rxStatus;
    logic        rxStatusValid;

    gem_ext_fifo_rx #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .gem             (gemIf),
        .m_axis          (axisIf),
        .rx_status       (rxStatus),
        .rx_status_valid (rxStatusValid)
    );

    int checks = 0;
    int errors = 0;
    int ovfSeen = 0;
    int beatSeen = 0;
    bit randReady = 1'b0;

    // Reference model state: frame position flags and expected beat queue.
    logic [9:0]  expQ[$];
    int          occ = 0;
    bit          inFrame = 1'b0;
    bit          dropping = 1'b0;
    bit          expOvf = 1'b0;
    bit          expTog = 1'b0;
    bit          endTogPrev = 1'b0;
    logic [44:0] expStatus = '0;
    bit          expStatusV = 1'b0;
    bit          mPop, mStore, mOvf, mEop;
    logic [9:0]  mEntry;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            expQ.delete();
            occ = 0; inFrame = 0; dropping = 0; expOvf = 0;
            expTog = 0; endTogPrev = 0; expStatus = '0; expStatusV = 0;
        end else begin
            mPop = (occ > 0) && axisIf.m_axis_tready;
            mStore = 0; mOvf = 0; mEop = 0; mEntry = '0;
            if (!inFrame && !dropping) begin
                if (gemIf.gem_rx_wr && gemIf.gem_rx_sop) begin
                    if (gemIf.gem_rx_eop) begin
                        if (occ < DEPTH) begin
                            mStore = 1; mEop = 1;
                            mEntry = {gemIf.gem_rx_err, 1'b1, gemIf.gem_rx_data};
                        end else mOvf = 1;
                    end else if (occ < DEPTH - 1) begin
                        mStore = 1; inFrame = 1; mEntry = {2'b00, gemIf.gem_rx_data};
                    end else begin
                        mOvf = 1; dropping = 1;
                    end
                end else if (gemIf.gem_rx_wr) mOvf = 1;
            end else if (inFrame) begin
                if (gemIf.gem_rx_flush) begin
                    mStore = 1; mEntry = 10'h300; inFrame = 0; dropping = 1;
                end else if (gemIf.gem_rx_wr) begin
                    if (gemIf.gem_rx_sop) begin
                        mStore = 1; mOvf = 1; mEntry = {2'b11, gemIf.gem_rx_data};
                        inFrame = 0; dropping = !gemIf.gem_rx_eop;
                    end else if (gemIf.gem_rx_eop) begin
                        mStore = 1; mEop = 1; inFrame = 0;
                        mEntry = {gemIf.gem_rx_err, 1'b1, gemIf.gem_rx_data};
                    end else if (occ < DEPTH - 1) begin
                        mStore = 1; mEntry = {2'b00, gemIf.gem_rx_data};
                    end else begin
                        mStore = 1; mOvf = 1; mEntry = {2'b11, gemIf.gem_rx_data};
                        inFrame = 0; dropping = 1;
                    end
                end
            end else if (gemIf.gem_rx_wr && gemIf.gem_rx_eop) begin
                dropping = 0;
            end
            if (mStore) begin
                expQ.push_back(mEntry);
                occ++;
            end
            if (mPop) occ--;
            expOvf = mOvf;
            if (gemIf.gem_dma_rx_end_tog != endTogPrev) expTog = !expTog;
            endTogPrev = gemIf.gem_dma_rx_end_tog;
`ifdef GEM_EXT_FIFO_RX_STATUS_EN
            expStatusV = mEop;
            if (mEop) expStatus = gemIf.gem_rx_status;
`endif
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        checkOutput("tvalid", axisIf.m_axis_tvalid, occ != 0);
        checkOutput("overflow", gemIf.gem_rx_overflow, expOvf);
        checkOutput("status_tog", gemIf.gem_dma_rx_status_tog, expTog);
        checkOutput("status_valid", rxStatusValid, expStatusV);
        checkOutput("status", rxStatus, expStatus);
        if (gemIf.gem_rx_overflow === 1'b1) ovfSeen++;
        if (axisIf.m_axis_tvalid === 1'b1 && axisIf.m_axis_tready === 1'b1) begin
            beatSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", {54'd0, axisIf.m_axis_tuser, axisIf.m_axis_tlast, axisIf.m_axis_tdata}, 64'hFFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("tdata", axisIf.m_axis_tdata, e[7:0]);
                checkOutput("tlast", axisIf.m_axis_tlast, e[8]);
                checkOutput("tuser", axisIf.m_axis_tuser, e[9]);
                checkOutput("tkeep", axisIf.m_axis_tkeep, 1'b1);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic sop, input logic eop, input logic err,
                                 input logic flush, input logic [7:0] data, input logic [44:0] st);
        gemIf.gem_rx_wr     = wr;
        gemIf.gem_rx_sop    = sop;
        gemIf.gem_rx_eop    = eop;
        gemIf.gem_rx_err    = err;
        gemIf.gem_rx_flush  = flush;
        gemIf.gem_rx_data   = data;
        gemIf.gem_rx_status = st;
        if (randReady) axisIf.m_axis_tready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        gemIf.gem_rx_wr    = 1'b0;
        gemIf.gem_rx_sop   = 1'b0;
        gemIf.gem_rx_eop   = 1'b0;
        gemIf.gem_rx_flush = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 8'h00, '0);
    endtask

    task automatic sendFrame(input int len, input logic [7:0] base, input logic err,
                             input logic noEop, input int flushAt, input logic [44:0] st);
        for (int i = 0; i < len; i++) begin
            if (i == flushAt) applyStimulus(0, 0, 0, 0, 1, 8'h00, '0);
            applyStimulus(1, i == 0, (i == len - 1) && !noEop, err, 0, base + 8'(i), st);
        end
    endtask

    task automatic drain();
        int n;
        randReady = 1'b0;
        axisIf.m_axis_tready = 1'b1;
        n = 0;
        while (occ != 0 && n < 200) begin
            idleCycles(1);
            n++;
        end
        idleCycles(1);
        checkOutput("drain_done", occ, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ovf0, beat0, len, flushAt;
        logic [63:0] r64;
        gemIf.gem_rx_data = '0; gemIf.gem_rx_wr = 0; gemIf.gem_rx_sop = 0;
        gemIf.gem_rx_eop = 0; gemIf.gem_rx_err = 0; gemIf.gem_rx_flush = 0;
        gemIf.gem_rx_status = '0; gemIf.gem_dma_rx_end_tog = 0;
        axisIf.m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        checkOutput("reset_tvalid", axisIf.m_axis_tvalid, 0);
        checkOutput("reset_overflow", gemIf.gem_rx_overflow, 0);
        checkOutput("reset_status_tog", gemIf.gem_dma_rx_status_tog, 0);
        idleCycles(2);

        $display("[TB] 64-byte frame, tready=1");
        axisIf.m_axis_tready = 1'b1;
        ovf0 = ovfSeen; beat0 = beatSeen;
        sendFrame(64, 8'h00, 0, 0, -1, '0);
        drain();
        checkOutput("full_rate_beats", beatSeen - beat0, 64);
        checkOutput("full_rate_ovf", ovfSeen - ovf0, 0);

        $display("[TB] 64-byte frame, tready=0");
        axisIf.m_axis_tready = 1'b0;
        ovf0 = ovfSeen; beat0 = beatSeen;
        sendFrame(64, 8'h00, 0, 0, -1, '0);
        idleCycles(2);
        checkOutput("stalled_occupancy_tvalid", axisIf.m_axis_tvalid, 1);
        checkOutput("stalled_ovf", ovfSeen - ovf0, 1);
        drain();
        checkOutput("stalled_beats", beatSeen - beat0, 16);
        beat0 = beatSeen;
        sendFrame(8, 8'h40, 0, 0, -1, '0);
        drain();
        checkOutput("after_drop_beats", beatSeen - beat0, 8);

        $display("[TB] error frame");
        beat0 = beatSeen;
        sendFrame(4, 8'hA0, 1, 0, -1, '0);
        drain();
        checkOutput("err_beats", beatSeen - beat0, 4);

        $display("[TB] flush after byte 3");
        ovf0 = ovfSeen; beat0 = beatSeen;
        sendFrame(10, 8'h10, 0, 0, 3, '0);
        drain();
        checkOutput("flush_beats", beatSeen - beat0, 4);
        checkOutput("flush_ovf", ovfSeen - ovf0, 0);

        $display("[TB] DMA toggle");
        idleCycles(10);
        gemIf.gem_dma_rx_end_tog = 1'b1;
        idleCycles(1);
        checkOutput("dma_tog_rise", gemIf.gem_dma_rx_status_tog, 1);
        idleCycles(9);
        gemIf.gem_dma_rx_end_tog = 1'b0;
        idleCycles(1);
        checkOutput("dma_tog_fall", gemIf.gem_dma_rx_status_tog, 0);
        gemIf.gem_dma_rx_end_tog = 1'b1;
        idleCycles(1);
        gemIf.gem_dma_rx_end_tog = 1'b0;
        idleCycles(1);
        checkOutput("dma_tog_back_to_back", gemIf.gem_dma_rx_status_tog, 0);

        $display("[TB] status capture");
        sendFrame(3, 8'h55, 0, 0, -1, 45'h1_2345_6789);
`ifdef GEM_EXT_FIFO_RX_STATUS_EN
        checkOutput("status_pulse", rxStatusValid, 1);
        checkOutput("status_value", rxStatus, 45'h1_2345_6789);
`else
        checkOutput("status_pulse", rxStatusValid, 0);
        checkOutput("status_value", rxStatus, 0);
`endif
        drain();

        $display("[TB] reset mid-frame");
        axisIf.m_axis_tready = 1'b0;
        sendFrame(5, 8'h80, 0, 1, -1, '0);
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_tvalid", axisIf.m_axis_tvalid, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        ovf0 = ovfSeen;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, i == 2, 0, 0, 8'(i), '0);
        idleCycles(2);
        checkOutput("post_reset_stray_ovf", ovfSeen - ovf0, 3);
        drain();

        $display("[TB] randomized frames");
        randReady = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0) applyStimulus(1, 0, 0, 0, 0, 8'($urandom()), '0);
            if ($urandom_range(0, 5) == 0) gemIf.gem_dma_rx_end_tog = !gemIf.gem_dma_rx_end_tog;
            len = $urandom_range(2, 30);
            flushAt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
            r64 = {$urandom(), $urandom()};
            randReady = 1'b1;
            sendFrame(len, 8'($urandom()), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7) == 0, flushAt, r64[44:0]);
            idleCycles($urandom_range(0, 3));
        end
        drain();
        checkOutput("queue_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
